// File: rtl/data_mem_if.sv
// Request/response bus between a memory initiator and a data-memory responder.
// Both channels use valid/ready: a beat transfers on a rising edge where valid and ready are both 1.
`timescale 1ns/1ps
interface data_mem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed access latency and one outstanding request.
// FSM IDLE -> WAIT (counts down WAIT_CYCLES) -> RESP (holds response until resp_ready).
`timescale 1ns/1ps
module data_mem_responder #(
  parameter int DEPTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  data_mem_if.slave  bus,
  output logic [1:0] dbg_state
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] mem [DEPTH];

  logic          err_w;
  logic [IW-1:0] idx_w;
  logic          access;

  assign err_w     = (addr_q[1:0] != 2'b00) || (addr_q >= 32'(4 * DEPTH));
  assign idx_w     = addr_q[IW+1:2];
  assign access    = (state == WAIT) && (cnt == 4'd0);
  assign dbg_state = state;

  // No reset on the array; gating with reset keeps an aborted store from committing.
  always_ff @(posedge clk) begin
    if (reset && access && write_q && !err_w) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx_w][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= 32'd0;
      bus.resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && bus.req_ready) begin
            state         <= WAIT;
            cnt           <= 4'(WAIT_CYCLES);
            bus.req_ready <= 1'b0;
            write_q       <= bus.req_write;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            wstrb_q       <= bus.req_wstrb;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_error <= err_w;
            bus.resp_rdata <= (!write_q && !err_w) ? mem[idx_w] : 32'd0;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 32'd0;
            bus.resp_error <= 1'b0;
            bus.req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a WAIT_CYCLES=2 instance driven by directed and random
// transactions against an array model, plus a WAIT_CYCLES=0 instance for the short-latency build.
`timescale 1ns/1ps
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  data_mem_if bus ();
  data_mem_if bus0 ();
  logic [1:0] st, st0;

  data_mem_responder #(.DEPTH(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .dbg_state(st)
  );
  data_mem_responder #(.DEPTH(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .dbg_state(st0)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] model [32];
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference behaviour: word array, byte-enable merge, alignment/range error rule.
  task automatic model_apply(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] s, output logic [31:0] rd, output logic e);
    e  = (a % 4 != 0) || (a >= 32'd128);
    rd = 32'd0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < 4; i++)
          if (s[i]) model[a / 4][8*i +: 8] = wd[8*i +: 8];
      end else begin
        rd = model[a / 4];
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input int bp);
    logic [31:0] erd, rd_seen;
    logic ee, er_seen;
    int n;
    model_apply(w, a, wd, s, erd, ee);
    exp_q.push_back(erd);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_wstrb  = s;
    bus.resp_ready = 1'($urandom_range(0, 1));
    tick();
    check("req_ready_busy", 32'(bus.req_ready), 32'd0);
    n = 0;
    while (!bus.resp_valid && n < 20) begin
      bus.req_valid  = 1'($urandom_range(0, 1));
      bus.req_write  = 1'($urandom_range(0, 1));
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      bus.req_wstrb  = 4'($urandom_range(0, 15));
      bus.resp_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd3);
    check("rdata", bus.resp_rdata, exp_q.pop_front());
    check("error", 32'(bus.resp_error), 32'(ee));
    rd_seen = bus.resp_rdata;
    er_seen = bus.resp_error;
    for (int k = 0; k < bp; k++) begin
      bus.resp_ready = 1'b0;
      tick();
      check("bp_valid", 32'(bus.resp_valid), 32'd1);
      check("bp_rdata", bus.resp_rdata, rd_seen);
      check("bp_error", 32'(bus.resp_error), 32'(er_seen));
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b0;
    tick();
    check("post_valid", 32'(bus.resp_valid), 32'd0);
    check("post_rdata", bus.resp_rdata, 32'd0);
    check("post_error", 32'(bus.resp_error), 32'd0);
    check("post_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic req0(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] rd, output logic er, output int n);
    bus0.req_valid = 1'b1;
    bus0.req_write = w;
    bus0.req_addr  = a;
    bus0.req_wdata = wd;
    bus0.req_wstrb = s;
    tick();
    bus0.req_valid = 1'($urandom_range(0, 1));
    bus0.req_write = ~w;
    bus0.req_addr  = a ^ 32'h0000_0004;
    bus0.req_wdata = ~wd;
    bus0.req_wstrb = 4'hF;
    n = 0;
    while (!bus0.resp_valid && n < 20) begin
      tick();
      n++;
    end
    rd = bus0.resp_rdata;
    er = bus0.resp_error;
    bus0.req_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    logic er;
    int n, r;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_wstrb = 0; bus.resp_ready = 1;
    bus0.req_valid = 0; bus0.req_write = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus0.req_wstrb = 0; bus0.resp_ready = 1;

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    check("rst_error", 32'(bus.resp_error), 32'd0);
    check("rst_state", 32'(st), 32'd0);
    check("rst0_req_ready", 32'(bus0.req_ready), 32'd0);
    reset = 1'b1;
    tick();
    check("rel_req_ready", 32'(bus.req_ready), 32'd1);
    check("rel0_req_ready", 32'(bus0.req_ready), 32'd1);

    // Fill every word so later loads have known contents
    for (int i = 0; i < 32; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 0);
    do_req(1'b1, 32'h0C, 32'h1122_3344, 4'hF, 0);
    do_req(1'b1, 32'h08, 32'h0000_0000, 4'hF, 0);

    // Directed load, partial store, error cases
    do_req(1'b0, 32'h0C, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h08, 32'hAABB_CCDD, 4'b0101, 0);
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 0);
    check("store_merge_const", model[2], 32'h00BB_00DD);
    do_req(1'b0, 32'h06, 32'h0, 4'h0, 0);
    do_req(1'b0, 32'h80, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h0A, 32'hFFFF_FFFF, 4'hF, 0);
    do_req(1'b1, 32'h84, 32'hFFFF_FFFF, 4'hF, 0);
    do_req(1'b0, 32'h08, 32'h0, 4'h0, 0);
    do_req(1'b0, 32'h04, 32'h0, 4'h0, 0);
    do_req(1'b1, 32'h0C, 32'hFFFF_FFFF, 4'h0, 0);
    do_req(1'b0, 32'h0C, 32'h0, 4'h0, 0);

    // Backpressure for 5 cycles
    do_req(1'b0, 32'h0C, 32'h0, 4'h0, 5);

    // Reset in the second WAIT cycle aborts a store to word 4
    bus.req_valid = 1; bus.req_write = 1; bus.req_addr = 32'h10;
    bus.req_wdata = 32'hDEAD_BEEF; bus.req_wstrb = 4'hF;
    tick();
    bus.req_valid = 0;
    tick();
    reset = 1'b0;
    tick();
    check("abort_req_ready", 32'(bus.req_ready), 32'd0);
    check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    reset = 1'b1;
    tick();
    check("abort_rel_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (4) begin
      tick();
      check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0);

    // Reset while a response is pending drops it
    bus.req_valid = 1; bus.req_write = 0; bus.req_addr = 32'h0C; bus.resp_ready = 0;
    tick();
    bus.req_valid = 0;
    repeat (4) tick();
    check("resp_pending", 32'(bus.resp_valid), 32'd1);
    reset = 1'b0;
    tick();
    check("resp_dropped", 32'(bus.resp_valid), 32'd0);
    reset = 1'b1;
    bus.resp_ready = 1;
    tick();
    check("resp_drop_req_ready", 32'(bus.req_ready), 32'd1);
    check("resp_drop_valid", 32'(bus.resp_valid), 32'd0);

    // Random traffic
    for (int t = 0; t < 60; t++) begin
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, 31) * 4);
      if (r == 7) a = a + 32'($urandom_range(1, 3));
      else if (r == 8) a = 32'd128 + 32'($urandom_range(0, 500) * 4);
      else if (r == 9) a = 32'hFFFF_FFFC;
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 3)));
    end

    // WAIT_CYCLES=0 instance, request inputs scrambled during WAIT
    req0(1'b1, 32'h14, 32'hCAFE_F00D, 4'hF, rd, er, n);
    check("w0_store_latency", 32'(n), 32'd1);
    check("w0_store_rdata", rd, 32'd0);
    check("w0_store_error", 32'(er), 32'd0);
    req0(1'b0, 32'h14, 32'h0, 4'h0, rd, er, n);
    check("w0_load_latency", 32'(n), 32'd1);
    check("w0_load_rdata", rd, 32'hCAFE_F00D);
    check("w0_load_error", 32'(er), 32'd0);
    req0(1'b0, 32'h15, 32'h0, 4'h0, rd, er, n);
    check("w0_misalign_rdata", rd, 32'd0);
    check("w0_misalign_error", 32'(er), 32'd1);
    req0(1'b0, 32'h14, 32'h0, 4'h0, rd, er, n);
    check("w0_reload_rdata", rd, 32'hCAFE_F00D);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: DEPTH, 32, number of 32-bit words in the internal array.
REQ-002 Parameter: WAIT_CYCLES, 2, extra wait cycles before each access completes (0..15).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_write  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_wstrb  input  4  byte enables for stores; bit i enables wdata[8i+7:8i].
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-015 resp_error  output  1  request was misaligned or out of range.

Function
REQ-016 FSM states: IDLE, WAIT, RESP. All outputs registered.
REQ-017 req_ready SHALL be 1 only in IDLE. A request is accepted at an edge where req_valid=1 and req_ready=1. IDLE->WAIT on acceptance, with wait counter loaded with WAIT_CYCLES and addr/wdata/wstrb/write captured.
REQ-018 In WAIT with counter != 0: decrement per edge. With counter == 0: perform access at that edge and go to RESP.
REQ-019 resp_valid SHALL first be visible WAIT_CYCLES+1 cycles after the acceptance edge (3 cycles at default).
REQ-020 In RESP, resp_valid, resp_rdata and resp_error SHALL hold stable until an edge with resp_ready=1. Then go to IDLE, clear resp_valid/resp_rdata/resp_error and set req_ready. There is no same-cycle back-to-back acceptance.
REQ-021 Index = captured addr[6:2] (log2(DEPTH) bits above bit 1).
REQ-022 Error if addr[1:0] != 0 or addr >= 4*DEPTH. On error: no array write, resp_rdata=0, resp_error=1.
REQ-023 Load: resp_rdata = full word at index; req_wstrb ignored.
REQ-024 Store: write only enabled bytes; other bytes unchanged. wstrb=0000 is a legal no-op store. resp_rdata=0, resp_error=0.
REQ-025 Request inputs SHALL be ignored outside IDLE; changes after acceptance do not affect the in-flight access.
REQ-026 resp_ready asserted outside RESP SHALL have no effect.
REQ-027 A load issued after a completed store to the same word SHALL return the updated data.
REQ-028 Array contents are loadable hierarchically by the testbench (readmemb) before reset is released.

Reset
REQ-029 While reset=0 at an edge: state IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, wait counter=0.
REQ-030 First edge with reset=1 SHALL set req_ready=1.
REQ-031 Reset SHALL NOT modify array contents.
REQ-032 Reset during WAIT SHALL abort the request. A store whose access edge has not occurred SHALL NOT be committed, and no response is produced.
REQ-033 Reset during RESP SHALL drop the pending response.

Verification
REQ-034 Preload word 3 = 0x11223344. Load addr 0x0C, resp_ready held 1 -> resp_valid after 3 cycles, rdata 0x11223344, error 0.
REQ-035 Store addr 0x08, wdata 0xAABBCCDD, wstrb 0101 over word 0x00000000, then load 0x08 -> 0x00BB00DD.
REQ-036 Load addr 0x06 (misaligned) and load addr 0x80 (out of range) -> error 1, rdata 0, array unchanged.
REQ-037 Backpressure: resp_ready=0 for 5 cycles after resp_valid -> outputs stable and req_ready=0 throughout. Handshake -> req_ready=1 on the next cycle.
REQ-038 Store to 0x10 with reset pulsed in the second WAIT cycle -> no response, word 4 unchanged, req_ready=1 on the first cycle after release.
REQ-039 WAIT_CYCLES=0 build: load -> resp_valid visible 1 cycle after acceptance. Input changes in WAIT ignored.
